// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative mul/div unit.
interface muldiv_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] oprand_1;
  logic [XLEN-1:0] oprand_2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, oprand_1, oprand_2, flush,
                  input  busy, done, result);
  modport slave  (input  start, funct3, oprand_1, oprand_2, flush,
                  output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: sign-magnitude operands, XLEN shift-add or
// restoring-divide steps, one sign-fix cycle, one done cycle.
module muldiv_unit #(parameter int XLEN = 32) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]     count;
  logic [2:0]        f3;
  logic              sign1, neg_q, div0;
  logic [XLEN-1:0]   opa;     // multiplicand (mul) or divisor (div)
  logic [2*XLEN-1:0] acc;     // product, or dividend/quotient in the low half
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   res_q;

  logic              accept, is_div, s1_in, s2_in;
  logic [XLEN-1:0]   abs1, abs2;
  logic [XLEN:0]     msum, shifted;
  logic [XLEN-1:0]   diff, quo_fix, rem_fix, fix_res;
  logic              qbit;
  logic [2*XLEN-1:0] prod;

  assign accept = (state == IDLE) && bus.start && !bus.flush;
  assign is_div = f3[2];

  // Signed operand 1: MULH, MULHSU, DIV, REM. Signed operand 2: MULH, DIV, REM.
  assign s1_in = bus.oprand_1[XLEN-1] &
                 ((bus.funct3[2] & ~bus.funct3[0]) | (~bus.funct3[2] & (bus.funct3[1] ^ bus.funct3[0])));
  assign s2_in = bus.oprand_2[XLEN-1] &
                 ((bus.funct3[2] & ~bus.funct3[0]) | (bus.funct3 == 3'b001));
  assign abs1  = s1_in ? -bus.oprand_1 : bus.oprand_1;
  assign abs2  = s2_in ? -bus.oprand_2 : bus.oprand_2;

  assign msum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opa : '0)};
  assign shifted = {rem, acc[XLEN-1]};
  assign qbit    = (shifted >= {1'b0, opa});
  assign diff    = shifted[XLEN-1:0] - opa;

  // A zero divisor needs only the quotient forced; the remainder path already
  // reproduces the dividend, and INT_MIN / -1 falls out of the magnitudes.
  assign prod    = neg_q ? -acc : acc;
  assign quo_fix = div0 ? '1 : (neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
  assign rem_fix = sign1 ? -rem : rem;
  assign fix_res = is_div ? (f3[1] ? rem_fix : quo_fix)
                          : ((f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (bus.flush) state_nxt = IDLE;
               else if (count == CW'(XLEN-1)) state_nxt = FIX;
      FIX:     state_nxt = bus.flush ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      f3    <= '0;
      sign1 <= 1'b0;
      neg_q <= 1'b0;
      div0  <= 1'b0;
      opa   <= '0;
      acc   <= '0;
      rem   <= '0;
      res_q <= '0;
    end else begin
      if (accept) begin
        count <= '0;
        f3    <= bus.funct3;
        sign1 <= s1_in;
        neg_q <= s1_in ^ s2_in;
        div0  <= (bus.oprand_2 == '0);
        opa   <= bus.funct3[2] ? abs2 : abs1;
        acc   <= {{XLEN{1'b0}}, (bus.funct3[2] ? abs1 : abs2)};
        rem   <= '0;
      end else if (state == CALC) begin
        count <= count + CW'(1);
        if (is_div) begin
          rem             <= qbit ? diff : shifted[XLEN-1:0];
          acc[XLEN-1:0]   <= {acc[XLEN-2:0], qbit};
        end else begin
          acc <= {msum, acc[XLEN-1:1]};
        end
      end
      if (state == FIX && !bus.flush) res_q <= fix_res;
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.result = res_q;
endmodule
